// File: rtl/hmul_pkg.sv
// Shared types and default geometry for the homomorphic multiply sequencer.
package hmul_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LOAD_A,
      LOAD_B,
      DRAIN
   } state_t;

   // Default configuration; the top-level parameters start from these.
   localparam int DEFAULT_WIDTH     = 10;
   localparam int DEFAULT_DIMENSION = 1;
   localparam int DEFAULT_DIM_WIDTH = 1;
   localparam int DEFAULT_PARALLEL  = 1;

   // Derived sizes for the default configuration.
   localparam int N_COEF = DEFAULT_DIMENSION + 1;
   localparam int N_PROD = 2 * DEFAULT_DIMENSION + 1;
   localparam int BEATS  = N_COEF / DEFAULT_PARALLEL;

endpackage

// File: rtl/hmul_beat_counter.sv
// Index counter shared by the load and drain phases: steps by a
// selectable amount and flags the beat that reaches the limit.
module hmul_beat_counter #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   input  logic [WIDTH-1:0] step,
   input  logic [WIDTH:0]   limit,
   output logic [WIDTH-1:0] count,
   output logic             last
);

   // One extra bit so count+step can equal limit without overflowing.
   logic [WIDTH:0] next_count;

   assign next_count = {1'b0, count} + {1'b0, step};
   assign last       = (next_count == limit);

   // Clear wins over increment so the terminal beat restarts the index at 0.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= next_count[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/homomorphic_multiply_sequencer.sv
// Initiator-side controller for the homomorphic multiplier: clears it,
// streams operand A (load) and operand B (multiply-accumulate), then drains
// the 2*DIMENSION+1 product coefficients.
// Optional feature macro: HMUL_SEQ_OPCOUNT_EN adds a 16-bit op_count output
// counting completed operations.
// (DIMENSION+1) must be a multiple of PARALLEL.
module homomorphic_multiply_sequencer
   import hmul_pkg::*;
#(
   parameter int CIPHERTEXT_WIDTH = DEFAULT_WIDTH,
   parameter int DIMENSION        = DEFAULT_DIMENSION,
   parameter int DIM_WIDTH        = DEFAULT_DIM_WIDTH,
   parameter int PARALLEL         = DEFAULT_PARALLEL
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] in_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [CIPHERTEXT_WIDTH-1:0]          out_data,
   output logic                                 out_last,
   output logic                                 busy,
   output logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] mul_op1,
   output logic [DIM_WIDTH:0]                   mul_row,
   output logic                                 mul_ciphertext_select,
   output logic                                 mul_en,
   output logic                                 mul_rst_n,
`ifdef HMUL_SEQ_OPCOUNT_EN
   output logic [15:0]                          op_count,
`endif
   input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] mul_result
);

   localparam int CW       = DIM_WIDTH + 1;
   localparam int NUM_COEF = DIMENSION + 1;
   localparam int NUM_PROD = 2 * DIMENSION + 1;

   localparam logic [CW-1:0] LOAD_STEP   = CW'(PARALLEL);
   localparam logic [CW-1:0] DRAIN_STEP  = CW'(1);
   localparam logic [CW:0]   LOAD_LIMIT  = (CW+1)'(NUM_COEF);
   localparam logic [CW:0]   DRAIN_LIMIT = (CW+1)'(NUM_PROD);

   state_t          state;
   logic            in_hs;
   logic            out_hs;
   logic            cnt_clear;
   logic            cnt_inc;
   logic [CW-1:0]   cnt_step;
   logic [CW:0]     cnt_limit;
   logic [CW-1:0]   cnt_count;
   logic            cnt_last;

   // in_ready / out_valid are only ever high in the load / drain states.
   assign in_hs  = in_valid && in_ready;
   assign out_hs = out_valid && out_ready;

   // Counter control: step by a beat while loading, by one while draining.
   // NOTE: every always_comb output gets a default first so no path
   // leaves a value unassigned and infers a latch.
   always_comb begin
      cnt_step  = LOAD_STEP;
      cnt_limit = LOAD_LIMIT;
      if (state == DRAIN) begin
         cnt_step  = DRAIN_STEP;
         cnt_limit = DRAIN_LIMIT;
      end
      cnt_inc   = in_hs || out_hs;
      cnt_clear = (state == CLEAR) || (cnt_inc && cnt_last);
   end

   hmul_beat_counter #(
      .WIDTH (CW)
   ) u_index (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (cnt_clear),
      .inc   (cnt_inc),
      .step  (cnt_step),
      .limit (cnt_limit),
      .count (cnt_count),
      .last  (cnt_last)
   );

   // Multiplier command path: the strobe and operand follow the input beat
   // combinationally, the result feeds straight through to out_data.
   assign mul_en    = in_hs;
   assign mul_op1   = in_ready ? in_data : '0;
   assign mul_row   = cnt_count;
   assign mul_rst_n = rst_n && (state != CLEAR);
   assign out_data  = out_valid ? mul_result[CIPHERTEXT_WIDTH-1:0] : '0;
   assign out_last  = out_valid && cnt_last;

   // Sequencer FSM with registered handshake and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                 <= IDLE;
         in_ready              <= 1'b0;
         out_valid             <= 1'b0;
         busy                  <= 1'b0;
         mul_ciphertext_select <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
               end
            end
            CLEAR: begin
               state                 <= LOAD_A;
               in_ready              <= 1'b1;
               mul_ciphertext_select <= 1'b0;
            end
            LOAD_A: begin
               if (in_hs && cnt_last) begin
                  state                 <= LOAD_B;
                  mul_ciphertext_select <= 1'b1;
               end
            end
            LOAD_B: begin
               if (in_hs && cnt_last) begin
                  state                 <= DRAIN;
                  in_ready              <= 1'b0;
                  out_valid             <= 1'b1;
                  mul_ciphertext_select <= 1'b0;
               end
            end
            DRAIN: begin
               if (out_hs && cnt_last) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state                 <= IDLE;
               in_ready              <= 1'b0;
               out_valid             <= 1'b0;
               busy                  <= 1'b0;
               mul_ciphertext_select <= 1'b0;
            end
         endcase
      end
   end

`ifdef HMUL_SEQ_OPCOUNT_EN
   // Completed-operation counter, wrapping at 2^16.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (out_hs && cnt_last) begin
         op_count <= op_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_homomorphic_multiply_sequencer.sv
// Bench for homomorphic_multiply_sequencer: a behavioural multiplier drives
// mul_result, a convolution model predicts each product stream, and one
// negedge monitor checks handshakes, strobes and output data every cycle.
module tb_homomorphic_multiply_sequencer;
   import hmul_pkg::*;

   localparam int W  = DEFAULT_WIDTH;
   localparam int D  = DEFAULT_DIMENSION;
   localparam int DW = DEFAULT_DIM_WIDTH;
   localparam int P  = DEFAULT_PARALLEL;

   typedef logic [W-1:0] coef_t;
   typedef coef_t coef_arr_t [N_COEF];
   typedef coef_t prod_arr_t [N_PROD];
   typedef struct {
      coef_t data;
      logic  last;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [P*W-1:0] in_data;
   logic           out_valid;
   logic           out_ready;
   coef_t          out_data;
   logic           out_last;
   logic           busy;
   logic [P*W-1:0] mul_op1;
   logic [DW:0]    mul_row;
   logic           mul_ciphertext_select;
   logic           mul_en;
   logic           mul_rst_n;
   logic [P*W-1:0] mul_result;
`ifdef HMUL_SEQ_OPCOUNT_EN
   logic [15:0]    op_count;
`endif

   homomorphic_multiply_sequencer #(
      .CIPHERTEXT_WIDTH (W),
      .DIMENSION        (D),
      .DIM_WIDTH        (DW),
      .PARALLEL         (P)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .in_valid              (in_valid),
      .in_ready              (in_ready),
      .in_data               (in_data),
      .out_valid             (out_valid),
      .out_ready             (out_ready),
      .out_data              (out_data),
      .out_last              (out_last),
      .busy                  (busy),
      .mul_op1               (mul_op1),
      .mul_row               (mul_row),
      .mul_ciphertext_select (mul_ciphertext_select),
      .mul_en                (mul_en),
      .mul_rst_n             (mul_rst_n),
`ifdef HMUL_SEQ_OPCOUNT_EN
      .op_count              (op_count),
`endif
      .mul_result            (mul_result)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural multiplier ----------------
   coef_t ma [N_COEF];
   coef_t mp [N_PROD];

   function automatic coef_t mac_at(input int i);
      coef_t acc;
      int    k;
      acc = mp[i];
      for (int j = 0; j < P; j++) begin
         k = i - int'(mul_row) - j;
         if (k >= 0 && k < N_COEF) acc = acc + coef_t'(ma[k] * mul_op1[j*W +: W]);
      end
      return acc;
   endfunction

   always @(posedge clk) begin
      if (!mul_rst_n) begin
         for (int i = 0; i < N_COEF; i++) ma[i] <= '0;
         for (int i = 0; i < N_PROD; i++) mp[i] <= '0;
      end else if (mul_en) begin
         if (!mul_ciphertext_select) begin
            for (int j = 0; j < P; j++)
               if (int'(mul_row) + j < N_COEF) ma[int'(mul_row) + j] <= mul_op1[j*W +: W];
         end else begin
            for (int i = 0; i < N_PROD; i++) mp[i] <= mac_at(i);
         end
      end
   end

   always_comb begin
      mul_result = '0;
      for (int j = 0; j < P; j++)
         if (int'(mul_row) + j < N_PROD) mul_result[j*W +: W] = mp[int'(mul_row) + j];
   end

   // ---------------- checking infrastructure ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int en_pulses  = 0;
   int clr_cycles = 0;
   int ops_done   = 0;
   int out_mode   = 0;
   int stall_n    = 0;
   exp_t  exp_q [$];
   coef_t got_q [$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference product: plain polynomial multiply, coefficients mod 2^W.
   function automatic void conv(input coef_arr_t a, input coef_arr_t b, output prod_arr_t p);
      for (int i = 0; i < N_PROD; i++) p[i] = '0;
      for (int i = 0; i < N_COEF; i++)
         for (int k = 0; k < N_COEF; k++)
            p[i+k] = p[i+k] + coef_t'(a[i] * b[k]);
   endfunction

   function automatic logic [P*W-1:0] pack(input coef_arr_t c, input int bt);
      logic [P*W-1:0] r;
      r = '0;
      for (int j = 0; j < P; j++) r[j*W +: W] = c[bt*P + j];
      return r;
   endfunction

   // Downstream ready driver: 0 always ready, 1 random, 2 stall 3 cycles at row 1.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (out_mode)
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin
               if (out_valid && mul_row == 1 && stall_n < 3) begin
                  out_ready = 1'b0;
                  stall_n++;
               end else begin
                  out_ready = 1'b1;
               end
            end
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Per-cycle monitor, sampled mid-cycle when all inputs have settled.
   initial begin
      logic  stall_seen;
      coef_t hold_data;
      logic [DW:0] hold_row;
      logic  hold_last;
      exp_t  e;
      stall_seen = 1'b0;
      hold_data  = '0;
      hold_row   = '0;
      hold_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_seen = 1'b0;
         end else begin
            check("mul_en_vs_handshake", 32'(mul_en), 32'(in_valid && in_ready));
            if (mul_en) en_pulses++;
            if (!mul_rst_n) clr_cycles++;
            if (out_valid) check("in_ready_in_drain", 32'(in_ready), 0);
            if (!out_valid) check("out_last_idle", 32'(out_last), 0);
            if (in_ready || out_valid || !mul_rst_n) check("busy", 32'(busy), 1);
            if (stall_seen) begin
               check("bp_valid_held", 32'(out_valid), 1);
               check("bp_data_held", 32'(out_data), 32'(hold_data));
               check("bp_row_held", 32'(mul_row), 32'(hold_row));
               check("bp_last_held", 32'(out_last), 32'(hold_last));
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_output", 32'(out_valid), 0);
               end else begin
                  e = exp_q.pop_front();
                  check("out_data", 32'(out_data), 32'(e.data));
                  check("out_last", 32'(out_last), 32'(e.last));
                  got_q.push_back(out_data);
               end
            end
            stall_seen = out_valid && !out_ready;
            hold_data  = out_data;
            hold_row   = mul_row;
            hold_last  = out_last;
         end
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic send_beat(input logic [P*W-1:0] data, input int gap_mode);
      bit ok;
      bit hs;
      int gaps;
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gaps) begin
         in_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = data;
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         hs = in_ready;
         @(posedge clk);
         #1;
         if (hs) begin
            ok = 1'b1;
            break;
         end
      end
      check("in_handshake", 32'(ok), 1);
   endtask

   task automatic run_op(input coef_arr_t a, input coef_arr_t b, input int gap_mode, input int omode);
      prod_arr_t p;
      exp_t e;
      int en0;
      int clr0;
      bit ok;
      conv(a, b, p);
      out_mode = omode;
      stall_n  = 0;
      got_q.delete();
      en0  = en_pulses;
      clr0 = clr_cycles;
      for (int bt = 0; bt < BEATS; bt++) send_beat(pack(a, bt), gap_mode);
      for (int bt = 0; bt < BEATS; bt++) send_beat(pack(b, bt), gap_mode);
      in_valid = 1'b0;
      for (int i = 0; i < N_PROD; i++) begin
         e.data = p[i];
         e.last = (i == N_PROD - 1);
         exp_q.push_back(e);
      end
      @(negedge clk);
      check("first_out_latency", 32'(out_valid), 1);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0 && !out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("drain_complete", 32'(ok), 1);
      check("mul_en_pulses", 32'(en_pulses - en0), 32'(2 * BEATS));
      check("clear_cycles", 32'(clr_cycles - clr0), 1);
      ops_done++;
`ifdef HMUL_SEQ_OPCOUNT_EN
      check("op_count", 32'(op_count), 32'(ops_done));
`endif
   endtask

   task automatic check_got(input string name, input prod_arr_t e);
      check({name, "_count"}, 32'(got_q.size()), 32'(N_PROD));
      for (int i = 0; i < N_PROD && i < got_q.size(); i++)
         check(name, 32'(got_q[i]), 32'(e[i]));
   endtask

   task automatic check_reset_outputs();
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_mul_en", 32'(mul_en), 0);
      check("rst_mul_row", 32'(mul_row), 0);
      check("rst_mul_op1", 32'(mul_op1), 0);
      check("rst_mul_select", 32'(mul_ciphertext_select), 0);
      check("rst_mul_rst_n", 32'(mul_rst_n), 0);
`ifdef HMUL_SEQ_OPCOUNT_EN
      check("rst_op_count", 32'(op_count), 0);
`endif
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      exp_q.delete();
      ops_done = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      coef_arr_t a_basic;
      coef_arr_t b_basic;
      coef_arr_t a_wrap;
      coef_arr_t b_wrap;
      coef_arr_t ones;
      coef_arr_t ra;
      coef_arr_t rb;
      prod_arr_t e_basic;
      prod_arr_t e_wrap;
      prod_arr_t e_ones;
      prod_arr_t p;

      a_basic = '{10'd3, 10'd5};
      b_basic = '{10'd2, 10'd7};
      a_wrap  = '{10'd1000, 10'd0};
      b_wrap  = '{10'd2, 10'd0};
      ones    = '{10'd1, 10'd1};
      e_basic = '{10'd6, 10'd31, 10'd35};
      e_wrap  = '{10'd976, 10'd0, 10'd0};
      e_ones  = '{10'd1, 10'd2, 10'd1};

      in_valid = 1'b0;
      in_data  = '0;
      rst_n    = 1'b0;
      #1;
      check_reset_outputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Pin the reference model to hand-computed products.
      conv(a_basic, b_basic, p);
      for (int i = 0; i < N_PROD; i++) check("model_basic", 32'(p[i]), 32'(e_basic[i]));
      conv(a_wrap, b_wrap, p);
      for (int i = 0; i < N_PROD; i++) check("model_wrap", 32'(p[i]), 32'(e_wrap[i]));
      conv(ones, ones, p);
      for (int i = 0; i < N_PROD; i++) check("model_ones", 32'(p[i]), 32'(e_ones[i]));

      // Basic, wrap, then back-to-back with no residue.
      run_op(a_basic, b_basic, 0, 0);
      check_got("basic", e_basic);
      check("in_ready_after_op", 32'(in_ready), 0);
      run_op(a_wrap, b_wrap, 0, 0);
      check_got("wrap", e_wrap);
      run_op(ones, ones, 0, 0);
      check_got("back_to_back", e_ones);

      // Input gaps and a 3-cycle stall on coefficient 1.
      run_op(a_basic, b_basic, 1, 2);
      check_got("gaps_backpressure", e_basic);
      check("stall_cycles", 32'(stall_n), 3);

      // Reset after the first B beat, then a clean operation.
      out_mode = 0;
      for (int bt = 0; bt < BEATS; bt++) send_beat(pack(a_basic, bt), 0);
      send_beat(pack(b_basic, 0), 0);
      in_valid = 1'b0;
      apply_reset();
      run_op(a_basic, b_basic, 0, 0);
      check_got("after_reset", e_basic);

      // Randomised operations with random gaps and backpressure.
      for (int n = 0; n < 25; n++) begin
         for (int i = 0; i < N_COEF; i++) begin
            ra[i] = coef_t'($urandom_range(0, (1 << W) - 1));
            rb[i] = coef_t'($urandom_range(0, (1 << W) - 1));
         end
         run_op(ra, rb, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
      end

      apply_reset();

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/homomorphic_multiply_sequencer.md
Name: homomorphic_multiply_sequencer

Overview:
Initiator-side controller for the homomorphic multiplier datapath. It accepts two ciphertext coefficient streams over a valid/ready input. It issues the multiplier's clear, load-first-operand and accumulate-second-operand commands (op1/row/select/en), then drains the 2*DIMENSION+1 product coefficients over a valid/ready output. It sits between the ciphertext buffer/DMA and the multiplier.

Parameters:
CIPHERTEXT_WIDTH, 10, coefficient width; all arithmetic is mod 2^CIPHERTEXT_WIDTH inside the multiplier.
DIMENSION, 1, polynomial degree; each operand has DIMENSION+1 coefficients.
DIM_WIDTH, 1, row index is DIM_WIDTH+1 bits and must hold 2*DIMENSION.
PARALLEL, 1, coefficients per input beat; (DIMENSION+1) % PARALLEL == 0 is required.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  PARALLEL*CIPHERTEXT_WIDTH  coefficients; lane j = bits [j*W +: W]
out_valid  out  1  product coefficient valid
out_ready  in  1  downstream accepts
out_data  out  CIPHERTEXT_WIDTH  product coefficient, index 0 first
out_last  out  1  high with coefficient 2*DIMENSION
busy  out  1  state != IDLE
mul_op1  out  PARALLEL*CIPHERTEXT_WIDTH  to multiplier op1
mul_row  out  DIM_WIDTH+1  to multiplier row
mul_ciphertext_select  out  1  0 = load A, 1 = multiply-accumulate B
mul_en  out  1  multiplier strobe
mul_rst_n  out  1  multiplier synchronous clear, active-low
mul_result  in  PARALLEL*CIPHERTEXT_WIDTH  from multiplier result_partial; lane 0 used

Behaviour:
- Reset (async, rst_n low): state=IDLE, counter=0; in_ready=0, out_valid=0, out_last=0, busy=0, mul_en=0, mul_row=0, mul_op1=0, mul_ciphertext_select=0. mul_rst_n=0 while rst_n is low.
- States: IDLE, CLEAR, LOAD_A, LOAD_B, DRAIN.
- IDLE: in_ready=0. When in_valid=1, go to CLEAR. No beat is consumed.
- CLEAR: exactly one cycle with mul_rst_n=0. Then LOAD_A with counter=0. The multiplier's clear is synchronous, so one edge is sufficient.
- LOAD_A: in_ready=1, mul_ciphertext_select=0, mul_row=counter, mul_op1=in_data. mul_en=in_valid (combinational).
  - On each handshake, counter+=PARALLEL.
  - After the beat with counter+PARALLEL == DIMENSION+1, go to LOAD_B with counter=0.
- LOAD_B: same as LOAD_A, but mul_ciphertext_select=1. After the last beat, go to DRAIN with counter=0.
- in_valid low during a load: hold state, mul_en=0. There are no spurious strobes.
- DRAIN: in_ready=0, out_valid=1, mul_row=counter, out_data=mul_result lane 0 (combinational through the multiplier), out_last=(counter==2*DIMENSION).
  - On handshake, counter+=1.
  - On the out_last handshake, go to IDLE.
  - First valid output appears in the cycle after the last B handshake (latency 1).
- Backpressure (out_ready=0): mul_row, out_data and out_last are held stable.
- Outside load states, mul_en=0. mul_rst_n=1 except in CLEAR or under reset.
- Reset mid-operation: the async return to IDLE also clears the multiplier via mul_rst_n. A partially loaded operation is discarded; the next operation starts from CLEAR.
- Back-to-back operations: in IDLE with in_valid already high, go IDLE→CLEAR→LOAD_A. This gives 2 bubble cycles between operations.

Optional Feature:
HMUL_SEQ_OPCOUNT_EN
- Defined: adds output op_count[15:0]. Reset 0. Increments on each out_last handshake and wraps at 2^16.
- Undefined: the port and counter are absent; there is no other behavioural difference.

Decomposition:
- Package hmul_pkg holds:
  - state enum (IDLE, CLEAR, LOAD_A, LOAD_B, DRAIN)
  - localparams N_COEF=DIMENSION+1, N_PROD=2*DIMENSION+1, BEATS=N_COEF/PARALLEL
- One sub-module is natural: hmul_beat_counter, an up-counter with step, clear and terminal-count flag, used for both load and drain indices.

Test Plan:
- Basic (DIMENSION=1, W=10): A=[3,5], B=[2,7] -> out_data 6, 31, 35; out_last on 35; in_ready low from 35 onward until the next operation.
- Wrap: A=[1000,0], B=[2,0] -> 976, 0, 0 (mod 1024).
- Back-to-back: after the Basic operation, A=[1,1], B=[1,1] -> 1, 2, 1. No residue from the previous operation; exactly one mul_rst_n low cycle between operations.
- Gaps and backpressure: in_valid toggled 1/0 across loads -> mul_en pulses equal handshakes (4 total). out_ready low 3 cycles at coefficient 1 -> out_data stays 31 with mul_row stable.
- Reset mid-LOAD_B: assert rst_n low after the first B beat -> outputs go to reset values immediately. A following full A=[3,5], B=[2,7] gives 6, 31, 35.
- HMUL_SEQ_OPCOUNT_EN: three complete operations -> op_count=3. Reset -> 0.
